logic_reduce_pipe: RTL

Parametrised, pipelined bitwise reduction unit. Combines N_IN operand vectors of WIDTH bits under a run-time-selected operation (AND, OR, XOR, inverted forms, two-term sum-of-products) with per-operand masking. Sits between a streaming producer and consumer with valid/ready handshakes and a fixed two-cycle latency. Keeps a saturating count of non-zero results for observability.

---
 rtl/logic_reduce_pipe.sv | 134 +++++++++++++
 1 files changed

// File: rtl/logic_reduce_pipe.sv
// Two-stage bitwise reduction unit with valid/ready flow control.
// Stage 1 holds identity-substituted operands; stage 2 holds the reduced result.
module logic_reduce_pipe #(
    parameter int N_IN    = 5,
    parameter int WIDTH   = 8,
    parameter int SPLIT   = 2,
    parameter int COUNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [N_IN-1:0]       in_mask,
    input  logic [2:0]            in_op,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_err,
    input  logic                  clr_count,
    output logic [COUNT_W-1:0]    hit_count
);
    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_SOP  = 3'd6;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (&v) ? v : v + COUNT_W'(1);
    endfunction

    logic               vld_p1, vld_p2;
    logic               s1_ready, s2_ready;
    logic [WIDTH-1:0]   ident_p0;
    logic [WIDTH-1:0]   opnd_p0 [N_IN];
    logic [WIDTH-1:0]   opnd_p1 [N_IN];
    logic [2:0]         op_p1;
    logic               a_empty_p1, b_empty_p1;
    logic [WIDTH-1:0]   and_all, or_all, xor_all, and_a, and_b;
    logic [WIDTH-1:0]   res_p1;
    logic               err_p1;
    logic [WIDTH-1:0]   data_p2;
    logic               err_p2;
    logic [COUNT_W-1:0] hits;

    assign s2_ready = !vld_p2 || out_ready;
    assign s1_ready = !vld_p1 || s2_ready;
    assign in_ready = s1_ready;

    // Stage 0 -> 1: masked operands become the identity of the selected operation
    always_comb begin
        ident_p0 = (in_op == OP_AND || in_op == OP_NAND || in_op == OP_SOP) ? '1 : '0;
        for (int k = 0; k < N_IN; k++)
            opnd_p0[k] = in_mask[k] ? ident_p0 : in_data[k*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_p1 <= 1'b0;
        else if (s1_ready)
            vld_p1 <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (in_valid && s1_ready) begin
            opnd_p1    <= opnd_p0;
            op_p1      <= in_op;
            a_empty_p1 <= &in_mask[SPLIT-1:0];
            b_empty_p1 <= &in_mask[N_IN-1:SPLIT];
        end
    end

    // Stage 1 -> 2: reduce; an SOP term with every operand masked contributes zero
    always_comb begin
        and_all = '1;
        or_all  = '0;
        xor_all = '0;
        and_a   = '1;
        and_b   = '1;
        for (int k = 0; k < N_IN; k++) begin
            and_all = and_all & opnd_p1[k];
            or_all  = or_all  | opnd_p1[k];
            xor_all = xor_all ^ opnd_p1[k];
            if (k < SPLIT)
                and_a = and_a & opnd_p1[k];
            else
                and_b = and_b & opnd_p1[k];
        end
        res_p1 = '0;
        err_p1 = 1'b0;
        case (op_p1)
            OP_AND:  res_p1 = and_all;
            OP_OR:   res_p1 = or_all;
            OP_XOR:  res_p1 = xor_all;
            OP_NAND: res_p1 = ~and_all;
            OP_NOR:  res_p1 = ~or_all;
            OP_XNOR: res_p1 = ~xor_all;
            OP_SOP:  res_p1 = (a_empty_p1 ? '0 : and_a) | (b_empty_p1 ? '0 : and_b);
            default: err_p1 = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2  <= 1'b0;
            data_p2 <= '0;
            err_p2  <= 1'b0;
        end else if (s2_ready) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                data_p2 <= res_p1;
                err_p2  <= err_p1;
            end
        end
    end

    // Output side: hit counter, clear wins over a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hits <= '0;
        else if (clr_count)
            hits <= '0;
        else if (vld_p2 && out_ready && data_p2 != '0)
            hits <= sat_inc(hits);
    end

    assign out_valid = vld_p2;
    assign out_data  = data_p2;
    assign out_err   = err_p2;
    assign hit_count = hits;
endmodule
